fetch_unit: RTL

//   Instruction fetch stage directly upstream of the decoder. Holds the PC,

---
 rtl/fetch_unit.sv | 117 +++++++++++
 1 files changed

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_unit
//  Purpose  : Instruction fetch stage feeding the decoder. Owns the PC, reads
//             16-bit instruction words from instruction memory over a req/ack
//             handshake and presents them on inst_out with a valid/stall
//             handshake. Supports jump redirect (with flush) and halt.
//  Ports    : clk        - clock, rising edge
//             res        - asynchronous active-low reset
//             imem_req   - fetch request to instruction memory (combinational)
//             imem_addr  - fetch address (the PC register)
//             imem_ack   - memory returns imem_rdata this cycle
//             imem_rdata - instruction word from memory
//             inst_out   - instruction to decoder
//             inst_valid - inst_out holds a valid instruction
//             inst_pc    - address of the instruction on inst_out
//             stall      - downstream cannot accept inst_out this cycle
//             jump       - redirect pulse from execute
//             jump_addr  - redirect target
//             halt       - stop fetching
//  Revision : 1.0 - initial release
// ============================================================================
module fetch_unit #(
    parameter int              AW       = 8,
    parameter logic [AW-1:0]   RESET_PC = '0,
    parameter logic [15:0]     NOP_INST = 16'h0000
) (
    input  logic          clk,
    input  logic          res,
    output logic          imem_req,
    output logic [AW-1:0] imem_addr,
    input  logic          imem_ack,
    input  logic [15:0]   imem_rdata,
    output logic [15:0]   inst_out,
    output logic          inst_valid,
    output logic [AW-1:0] inst_pc,
    input  logic          stall,
    input  logic          jump,
    input  logic [AW-1:0] jump_addr,
    input  logic          halt
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_HALT = 2'd2;

    localparam logic [AW-1:0] c_pc_one = {{(AW-1){1'b0}}, 1'b1};

    logic [1:0]    r_state;
    logic [AW-1:0] r_pc;
    logic [15:0]   r_inst;
    logic          r_valid;
    logic [AW-1:0] r_inst_pc;

    logic          w_req;
    logic          w_accept;
    logic          w_transfer;

    // A held (stalled) instruction blocks new fetches; a jump cycle never
    // requests because its target is not in the PC yet.
    assign w_req      = (r_state == S_RUN) && !(r_valid && stall) && !jump;
    assign w_accept   = w_req && imem_ack;
    assign w_transfer = r_valid && !stall;

    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            r_state   <= S_IDLE;
            r_pc      <= RESET_PC;
            r_inst    <= NOP_INST;
            r_valid   <= 1'b0;
            r_inst_pc <= '0;
        end else if (jump && (r_state != S_IDLE)) begin
            // Redirect flushes the output slot; any ack this cycle is dropped
            // (w_req is low, so nothing was accepted).
            r_state <= S_RUN;
            r_pc    <= jump_addr;
            r_valid <= 1'b0;
            r_inst  <= NOP_INST;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_state <= S_RUN;
                end
                S_RUN: begin
                    if (halt) begin
                        // Halt discards a same-cycle ack and keeps the PC.
                        r_state <= S_HALT;
                        r_valid <= 1'b0;
                        r_inst  <= NOP_INST;
                    end else if (w_accept) begin
                        r_inst    <= imem_rdata;
                        r_valid   <= 1'b1;
                        r_inst_pc <= r_pc;
                        r_pc      <= r_pc + c_pc_one;
                    end else if (w_transfer) begin
                        r_valid <= 1'b0;
                        r_inst  <= NOP_INST;
                    end
                end
                S_HALT: begin
                    r_state <= S_HALT;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign imem_req   = w_req;
    assign imem_addr  = r_pc;
    assign inst_out   = r_inst;
    assign inst_valid = r_valid;
    assign inst_pc    = r_inst_pc;

endmodule
`default_nettype wire
